// File: rtl/dram_pkg.sv
// dram_pkg: shared widths and FSM state encoding for the DRAM request arbiter
package dram_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/dram_req_arbiter_rr.sv
// rr_arbiter: round-robin pick starting after last_gnt; in req, last_gnt; out one-hot gnt, gnt_idx
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt_idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[IW'((int'(last_gnt) + k) % N)]) gnt_idx = IW'((int'(last_gnt) + k) % N);
  end
  assign gnt = (|req) ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin core load/store to single-port DRAM; core req/we/addr/wdata in, ack/err/rdata/busy out, dram addr/data_in/write_en out, data_out in
module dram_req_arbiter
  import dram_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_LIMIT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [ADDR_W*NUM_CORES-1:0]   core_addr,
  input  logic [DATA_W*NUM_CORES-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic                          core_err,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          busy,
  output logic                          dram_write_en,
  output logic [ADDR_W-1:0]             dram_addr,
  output logic [DATA_W-1:0]             dram_data_in,
  input  logic [DATA_W-1:0]             dram_data_out
);
  localparam int IW = $clog2(NUM_CORES);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(ADDR_LIMIT);
  state_t state, state_nx;
  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_CORES-1:0] gnt_oh, gnt_q;
  logic [IW-1:0] gnt_idx, last_gnt;
  logic we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  assign addr_v = core_addr;
  assign wdata_v = core_wdata;
  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req      (core_req),
    .last_gnt (last_gnt),
    .gnt      (gnt_oh),
    .gnt_idx  (gnt_idx)
  );
  always_comb begin
    state_nx = state == IDLE    ? (|core_req ? (addr_v[gnt_idx] > LIM ? DONE : ACCESS) : IDLE) :
               state == ACCESS  ? (we_q ? DONE : CAPTURE) :
               state == CAPTURE ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      last_gnt <= IW'(NUM_CORES - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE && |core_req) begin
        we_q     <= core_we[gnt_idx];
        addr_q   <= addr_v[gnt_idx];
        wdata_q  <= wdata_v[gnt_idx];
        err_q    <= addr_v[gnt_idx] > LIM;
        gnt_q    <= gnt_oh;
        last_gnt <= gnt_idx;
      end
      if (state == CAPTURE) rdata_q <= dram_data_out;
    end
  end
  assign core_ack      = state == DONE ? gnt_q : '0;
  assign core_err      = state == DONE && err_q;
  assign core_rdata    = rdata_q;
  assign busy          = state != IDLE;
  assign dram_write_en = state == ACCESS && we_q && rst_n;
  assign dram_addr     = addr_q;
  assign dram_data_in  = wdata_q;
endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Initiator side of the shared single-port DRAM interface. Each DRAM port is 16-bit address, 16-bit data, write_en; a read returns data one cycle after the address is presented.
- Accepts load/store requests from NUM_CORES cores over a req/ack handshake.
- Arbitrates round-robin, drives one DRAM access at a time, and returns read data plus a one-cycle ack to the winning core.
- Sits between the core load/store units and the DRAM.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_LIMIT, 1024, highest legal word address; requests above it are rejected.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- core_req  in  NUM_CORES  per-core request, held high until that core's ack.
- core_we  in  NUM_CORES  per-core 1=write, 0=read; stable while req high.
- core_addr  in  16*NUM_CORES  per-core word address; core i at bits [16i+15:16i].
- core_wdata  in  16*NUM_CORES  per-core write data, same packing.
- core_ack  out  NUM_CORES  one-hot, one-cycle completion strobe.
- core_err  out  1  valid with the ack; 1 = address out of range, no access made.
- core_rdata  out  16  read data, valid while ack is high, broadcast to all cores.
- busy  out  1  high in any state other than IDLE.
- dram_write_en  out  1  to DRAM write_en.
- dram_addr  out  16  to DRAM addr.
- dram_data_in  out  16  to DRAM data_in.
- dram_data_out  in  16  from DRAM data_out.

Behaviour:
- Reset, sampled at rising edge with rst_n=0:
  - state=IDLE.
  - core_ack=0, core_err=0, core_rdata=0, busy=0.
  - Latched we/addr/wdata cleared to 0.
  - Round-robin pointer last_gnt=NUM_CORES-1, so core 0 has first priority.
- dram_write_en = (state==ACCESS) & we_q & rst_n. No DRAM write can occur at an edge where reset is sampled.
- dram_addr = addr_q and dram_data_in = wdata_q in every state.
- IDLE:
  - If any core_req is high, pick the first requester searching last_gnt+1, last_gnt+2, ... modulo NUM_CORES.
  - Latch that core's we/addr/wdata into we_q/addr_q/wdata_q, set gnt_q, update last_gnt.
  - If addr > ADDR_LIMIT, go to DONE with err_q=1. Otherwise go to ACCESS with err_q=0.
  - If no core_req is high, stay in IDLE.
- ACCESS:
  - DRAM samples addr_q and write_en at the closing edge.
  - we_q=1: go to DONE.
  - we_q=0: go to CAPTURE.
- CAPTURE: dram_data_out is valid. At the closing edge latch rdata_q <= dram_data_out, then go to DONE.
- DONE:
  - core_ack[gnt_q]=1 and core_err=err_q for exactly one cycle.
  - core_rdata=rdata_q: read value for reads; unchanged from the previous read for writes and errors.
  - Always return to IDLE.
- Latency, counting the cycle req is first high in IDLE as cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 3.
  - Error: ack in cycle 1.
- Throughput is one access per 3 (write) or 4 (read) cycles.
- Handshake rules:
  - A core drops req in the cycle after its ack.
  - A req still high in IDLE is treated as a new request.
  - A core may change its fields only while req is low.
- Fairness: the granted core has lowest priority for the next arbitration. No core waits more than NUM_CORES-1 grants.
- Simultaneous events: requests arriving in a non-IDLE state wait; they are not lost, because req is held.
- Reset mid-operation: the in-flight access is abandoned. No ack is issued and no DRAM write is performed if reset is sampled during ACCESS.
- Addresses are unsigned 16-bit. No wrap or modification is applied.

Decomposition:
- Package dram_pkg:
  - DATA_W=16, ADDR_W=16.
  - State encoding: IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2, DONE=2'd3.
- Sub-module rr_arbiter(NUM_CORES):
  - Inputs: req vector, last_gnt pointer.
  - Outputs: one-hot grant and grant index (combinational).
- Top module holds the FSM, latches and pointer register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all core_req=1 -> core_ack=0, busy=0, dram_write_en=0, core_rdata=0 throughout.
- Write then read, core 1:
  - Write addr 0x000A, data 0x0055 -> dram_write_en=1 only in cycle 1; core_ack=4'b0010 in cycle 2; core_err=0.
  - Then read 0x000A -> ack in cycle 3 with core_rdata=0x0055.
- Simultaneous reads: all four cores read distinct preloaded addresses (0..3 holding 3,3,3,12) after reset -> acks in order core0, core1, core2, core3 with rdata 3,3,3,12; each grant is 4 cycles apart.
- Fairness: core 0 re-requests immediately after its ack while core 2 waits -> core 2 is acked before core 0's second access.
- Out of range: core 3 writes addr 0x0401 -> ack+err in cycle 1; dram_write_en never asserted; a later read of 0x0001 returns its unchanged value.
- Reset mid-write: core 0 writes 0x1234 to addr 5 (old value 0x0000); pull rst_n low during ACCESS -> no ack, dram_write_en=0; a read of addr 5 after reset returns 0x0000.
